// File: rtl/sram_axi_slave.sv
// AXI4 slave in front of a single-port 32-bit SRAM macro.
// One transaction at a time; SRAM strobes are combinational so each beat costs one cycle.
module sram_axi_slave #(
  parameter int ID_W    = 8,
  parameter int SRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ID_W-1:0]    AWID_S,
  input  logic [31:0]        AWADDR_S,
  input  logic [3:0]         AWLEN_S,
  input  logic [2:0]         AWSIZE_S,
  input  logic [1:0]         AWBURST_S,
  input  logic               AWVALID_S,
  output logic               AWREADY_S,
  input  logic [31:0]        WDATA_S,
  input  logic [3:0]         WSTRB_S,
  input  logic               WLAST_S,
  input  logic               WVALID_S,
  output logic               WREADY_S,
  output logic [ID_W-1:0]    BID_S,
  output logic [1:0]         BRESP_S,
  output logic               BVALID_S,
  input  logic               BREADY_S,
  input  logic [ID_W-1:0]    ARID_S,
  input  logic [31:0]        ARADDR_S,
  input  logic [3:0]         ARLEN_S,
  input  logic [2:0]         ARSIZE_S,
  input  logic [1:0]         ARBURST_S,
  input  logic               ARVALID_S,
  output logic               ARREADY_S,
  output logic [ID_W-1:0]    RID_S,
  output logic [31:0]        RDATA_S,
  output logic [1:0]         RRESP_S,
  output logic               RLAST_S,
  output logic               RVALID_S,
  input  logic               RREADY_S,
  output logic               CS,
  output logic               OE,
  output logic [3:0]         WEB,
  output logic [SRAM_AW-1:0] A,
  output logic [31:0]        DI,
  input  logic [31:0]        DO
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] WRESP = 2'd3;

  logic [1:0]         state;
  logic [ID_W-1:0]    rid_q, bid_q;
  logic [SRAM_AW-1:0] addr_q, addr_nxt;
  logic [3:0]         len_q, cnt_q;
  logic [1:0]         burst_q;
  logic               ar_hs, aw_hs, r_hs, w_hs, b_hs, rlast;

  // Only 32-bit transfers are supported; size, AWLEN and sub-word address bits are don't-care.
  logic unused_ok;
  assign unused_ok = ^{AWLEN_S, AWSIZE_S, ARSIZE_S, AWADDR_S[31:SRAM_AW+2], AWADDR_S[1:0],
                       ARADDR_S[31:SRAM_AW+2], ARADDR_S[1:0]};

  assign ar_hs = (state == IDLE) && ARVALID_S;
  assign aw_hs = (state == IDLE) && AWVALID_S && !ARVALID_S;
  assign r_hs  = (state == READ) && RREADY_S;
  assign w_hs  = (state == WRITE) && WVALID_S;
  assign b_hs  = (state == WRESP) && BREADY_S;
  assign rlast = (cnt_q == len_q);

  // FIXED holds the address; INCR and WRAP both step and wrap at the top of the macro.
  assign addr_nxt = (burst_q == 2'b00) ? addr_q : addr_q + 1'b1;

  assign ARREADY_S = (state == IDLE);
  assign AWREADY_S = (state == IDLE) && !ARVALID_S;
  assign RVALID_S  = (state == READ);
  assign RLAST_S   = (state == READ) && rlast;
  assign RDATA_S   = (state == READ) ? DO : 32'h0;
  assign RID_S     = rid_q;
  assign RRESP_S   = 2'b00;
  assign WREADY_S  = (state == WRITE);
  assign BVALID_S  = (state == WRESP);
  assign BID_S     = bid_q;
  assign BRESP_S   = 2'b00;

  // SRAM strobes derive from the state register, so async reset kills a write instantly.
  always_comb begin
    CS  = 1'b0;
    OE  = 1'b0;
    WEB = 4'hf;
    A   = '0;
    DI  = 32'h0;
    case (state)
      IDLE: if (ARVALID_S && rst) begin
        CS = 1'b1;
        OE = 1'b1;
        A  = ARADDR_S[SRAM_AW+1:2];
      end
      READ: begin
        CS = 1'b1;
        OE = 1'b1;
        // Advance on the handshake so the next word is on DO one cycle later.
        A  = (r_hs && !rlast) ? addr_nxt : addr_q;
      end
      WRITE: if (WVALID_S) begin
        CS  = 1'b1;
        WEB = ~WSTRB_S;
        DI  = WDATA_S;
        A   = addr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rid_q   <= '0;
      bid_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs) begin
            rid_q   <= ARID_S;
            addr_q  <= ARADDR_S[SRAM_AW+1:2];
            len_q   <= ARLEN_S;
            burst_q <= ARBURST_S;
            cnt_q   <= '0;
            state   <= READ;
          end else if (aw_hs) begin
            bid_q   <= AWID_S;
            addr_q  <= AWADDR_S[SRAM_AW+1:2];
            burst_q <= AWBURST_S;
            state   <= WRITE;
          end
        end
        READ: if (r_hs) begin
          if (rlast) state <= IDLE;
          else begin
            cnt_q  <= cnt_q + 1'b1;
            addr_q <= addr_nxt;
          end
        end
        WRITE: if (w_hs) begin
          addr_q <= addr_nxt;
          if (WLAST_S) state <= WRESP;
        end
        WRESP: if (b_hs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_axi_slave.sv
// Directed bench for sram_axi_slave with a behavioural single-port SRAM model.
module tb_sram_axi_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  AWID_S = '0, BID_S, ARID_S = '0, RID_S;
  logic [31:0] AWADDR_S = '0, WDATA_S = '0, ARADDR_S = '0, RDATA_S, DI, DO;
  logic [3:0]  AWLEN_S = '0, WSTRB_S = '0, ARLEN_S = '0, WEB;
  logic [2:0]  AWSIZE_S = 3'd2, ARSIZE_S = 3'd2;
  logic [1:0]  AWBURST_S = 2'b01, ARBURST_S = 2'b01, BRESP_S, RRESP_S;
  logic        AWVALID_S = 0, AWREADY_S, WLAST_S = 0, WVALID_S = 0, WREADY_S;
  logic        BVALID_S, BREADY_S = 0, ARVALID_S = 0, ARREADY_S;
  logic        RLAST_S, RVALID_S, RREADY_S = 0, CS, OE;
  logic [13:0] A;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:16383];
  logic        pl_we = 0;
  logic [13:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (CS) begin
      if (OE) DO <= mem[A];
      for (int b = 0; b < 4; b++)
        if (!WEB[b]) mem[A][b*8 +: 8] <= DI[b*8 +: 8];
    end
  end

  sram_axi_slave #(.ID_W(8), .SRAM_AW(14)) dut (
    .clk(clk), .rst(rst),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
    .WREADY_S(WREADY_S), .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
    .BREADY_S(BREADY_S), .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
    .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S),
    .ARREADY_S(ARREADY_S), .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S),
    .RLAST_S(RLAST_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [13:0] ad, input logic [31:0] d);
    pl_we = 1; pl_addr = ad; pl_data = d;
    tick();
    pl_we = 0;
  endtask

  task automatic rd1(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    ARVALID_S = 1; ARADDR_S = addr; ARLEN_S = 0; ARBURST_S = 2'b01; ARID_S = 8'h77;
    RREADY_S = 1;
    tick();
    ARVALID_S = 0;
    #1;
    chk({tag, "_rvalid"}, RVALID_S, 1);
    chk({tag, "_rdata"}, RDATA_S, exp);
    tick();
    #1;
    chk({tag, "_done"}, RVALID_S, 0);
    RREADY_S = 0;
  endtask

  task automatic bresp(input logic [7:0] id, input string tag);
    #1;
    chk({tag, "_bvalid"}, BVALID_S, 1);
    chk({tag, "_bid"}, BID_S, id);
    chk({tag, "_bresp"}, BRESP_S, 0);
    BREADY_S = 1;
    tick();
    BREADY_S = 0;
    #1;
    chk({tag, "_bdone"}, BVALID_S, 0);
  endtask

  initial begin
    // Reset values
    #1;
    chk("rst_arready", ARREADY_S, 1);
    chk("rst_awready", AWREADY_S, 1);
    chk("rst_valids", {RVALID_S, BVALID_S, WREADY_S}, 0);
    chk("rst_sram", {CS, OE, WEB, A}, {2'b00, 4'hf, 14'h0});
    chk("rst_ids", {RID_S, BID_S, RDATA_S, RLAST_S}, 0);
    ARVALID_S = 1;
    #1;
    chk("rst_awready_arv", AWREADY_S, 0);
    ARVALID_S = 0;

    preload(14'd4, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) preload(14'(i), 32'h100 + i);
    preload(14'd8, 32'hAAAAAAAA);
    preload(14'd16, 32'h0);
    preload(14'd17, 32'h77);
    rst = 1;
    tick();

    // Single read at 0x10
    ARVALID_S = 1; ARADDR_S = 32'h10; ARLEN_S = 0; ARID_S = 8'h5A; ARBURST_S = 2'b01;
    #1;
    chk("t1_a", A, 14'd4);
    chk("t1_csoe", {CS, OE}, 2'b11);
    tick();
    ARVALID_S = 0;
    #1;
    chk("t1_rvalid", RVALID_S, 1);
    chk("t1_rdata", RDATA_S, 32'hDEADBEEF);
    chk("t1_rlast", RLAST_S, 1);
    chk("t1_rresp", RRESP_S, 0);
    chk("t1_rid", RID_S, 8'h5A);
    RREADY_S = 1;
    tick();
    #1;
    chk("t1_idle", {RVALID_S, CS, OE}, 0);

    // 4-beat INCR read with stall on beat 1
    ARVALID_S = 1; ARADDR_S = 32'h0; ARLEN_S = 3; ARID_S = 8'h21;
    tick();
    ARVALID_S = 0;
    #1;
    chk("t2_b0", RDATA_S, 32'h100);
    chk("t2_b0_last", RLAST_S, 0);
    tick();
    RREADY_S = 0;
    #1;
    chk("t2_b1", RDATA_S, 32'h101);
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      chk("t2_stall_valid", RVALID_S, 1);
      chk("t2_stall_data", RDATA_S, 32'h101);
      chk("t2_stall_last", RLAST_S, 0);
    end
    RREADY_S = 1;
    tick();
    #1;
    chk("t2_b2", RDATA_S, 32'h102);
    chk("t2_b2_last", RLAST_S, 0);
    tick();
    #1;
    chk("t2_b3", RDATA_S, 32'h103);
    chk("t2_b3_last", RLAST_S, 1);
    tick();
    #1;
    chk("t2_done", RVALID_S, 0);
    RREADY_S = 0;

    // Partial-strobe write to word 8
    AWVALID_S = 1; AWADDR_S = 32'h20; AWID_S = 8'h33; AWLEN_S = 0; AWBURST_S = 2'b01;
    #1;
    chk("t3_awready", AWREADY_S, 1);
    tick();
    AWVALID_S = 0;
    #1;
    chk("t3_wready", WREADY_S, 1);
    WVALID_S = 1; WDATA_S = 32'h11223344; WSTRB_S = 4'b0011; WLAST_S = 1;
    #1;
    chk("t3_web", WEB, 4'b1100);
    chk("t3_a", A, 14'd8);
    chk("t3_di", DI, 32'h11223344);
    tick();
    WVALID_S = 0; WLAST_S = 0;
    #1;
    chk("t3_wready_off", WREADY_S, 0);
    tick();
    #1;
    chk("t3_bhold", BVALID_S, 1);
    bresp(8'h33, "t3");
    rd1(32'h20, 32'hAAAA3344, "t3_rd");

    // Simultaneous AR and AW: read first
    ARVALID_S = 1; ARADDR_S = 32'h20; ARLEN_S = 0; ARID_S = 8'h44;
    AWVALID_S = 1; AWADDR_S = 32'h30; AWID_S = 8'h55;
    #1;
    chk("t4_awready", AWREADY_S, 0);
    chk("t4_arready", ARREADY_S, 1);
    tick();
    ARVALID_S = 0; RREADY_S = 1;
    #1;
    chk("t4_rdata", RDATA_S, 32'hAAAA3344);
    chk("t4_rid", RID_S, 8'h44);
    chk("t4_awready_rd", AWREADY_S, 0);
    tick();
    RREADY_S = 0;
    #1;
    chk("t4_awready_idle", AWREADY_S, 1);
    tick();
    AWVALID_S = 0;
    WVALID_S = 1; WDATA_S = 32'hCAFEF00D; WSTRB_S = 4'hf; WLAST_S = 1;
    tick();
    WVALID_S = 0; WLAST_S = 0;
    bresp(8'h55, "t4");
    rd1(32'h30, 32'hCAFEF00D, "t4_rd");

    // INCR write wrapping from the top word
    AWVALID_S = 1; AWADDR_S = 32'hFFFC; AWID_S = 8'h66; AWLEN_S = 1; AWBURST_S = 2'b01;
    tick();
    AWVALID_S = 0;
    WVALID_S = 1; WDATA_S = 32'h11110001; WSTRB_S = 4'hf; WLAST_S = 0;
    #1;
    chk("t5_a0", A, 14'h3FFF);
    tick();
    WDATA_S = 32'h22220002; WLAST_S = 1;
    #1;
    chk("t5_a1", A, 14'h0);
    tick();
    WVALID_S = 0; WLAST_S = 0;
    bresp(8'h66, "t5");
    rd1(32'h0, 32'h22220002, "t5_rd0");
    rd1(32'hFFFC, 32'h11110001, "t5_rdtop");

    // FIXED read, len 2
    ARVALID_S = 1; ARADDR_S = 32'h8; ARLEN_S = 2; ARBURST_S = 2'b00; ARID_S = 8'h12;
    tick();
    ARVALID_S = 0; RREADY_S = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5f_data", RDATA_S, 32'h102);
      chk("t5f_a", A, 14'd2);
      chk("t5f_last", RLAST_S, (i == 2) ? 1 : 0);
      tick();
    end
    #1;
    chk("t5f_done", RVALID_S, 0);
    RREADY_S = 0; ARBURST_S = 2'b01;

    // Reset during beat 2 of a 4-beat write
    AWVALID_S = 1; AWADDR_S = 32'h40; AWID_S = 8'h99; AWLEN_S = 3;
    tick();
    AWVALID_S = 0;
    WVALID_S = 1; WDATA_S = 32'hAAAA0001; WSTRB_S = 4'hf; WLAST_S = 0;
    tick();
    WDATA_S = 32'hBBBB0002;
    #1;
    chk("t6_web_pre", WEB, 4'h0);
    rst = 0;
    #1;
    chk("t6_web_rst", WEB, 4'hf);
    chk("t6_cs_rst", CS, 0);
    chk("t6_wready_rst", WREADY_S, 0);
    chk("t6_bid_rst", BID_S, 0);
    chk("t6_arready_rst", ARREADY_S, 1);
    tick();
    WVALID_S = 0;
    rst = 1;
    tick();
    #1;
    chk("t6_no_b", BVALID_S, 0);
    rd1(32'h44, 32'h77, "t6_rd17");
    rd1(32'h40, 32'hAAAA0001, "t6_rd16");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
